// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - in-flight result tracker with operand forwarding and load-use stall
module forward_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_wen,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] src_b,
  output logic [2:0]        fwd_sel_a,
  output logic [2:0]        fwd_sel_b,
  output logic              stall,
  output logic [15:0]       stall_count
);

  // Entry k is the instruction k cycles past execute; index 1 is the youngest.
  logic              e_valid [1:DEPTH];
  logic [REG_AW-1:0] e_rd    [1:DEPTH];
  logic [DATA_W-1:0] e_data  [1:DEPTH];
  logic              e_ready [1:DEPTH];

  logic haz_a;
  logic haz_b;
  logic ins_valid;

  // A killed, stalled, non-writing or r0-targeting instruction enters as a bubble.
  assign ins_valid = ex_valid & ex_wen & ~flush & ~stall & (ex_rd != '0);

  // Shift the tracker every cycle; a pending load picks up mem_data as it leaves LOAD_STAGE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        e_valid[k] <= 1'b0;
        e_rd[k]    <= '0;
        e_data[k]  <= '0;
        e_ready[k] <= 1'b0;
      end
    end else begin
      e_valid[1] <= ins_valid;
      e_rd[1]    <= ex_rd;
      e_data[1]  <= ex_result;
      e_ready[1] <= ~ex_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_rd[k]    <= e_rd[k-1];
        if ((k - 1 == LOAD_STAGE) && !e_ready[k-1]) begin
          e_data[k]  <= mem_data;
          e_ready[k] <= 1'b1;
        end else begin
          e_data[k]  <= e_data[k-1];
          e_ready[k] <= e_ready[k-1];
        end
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer is the last one written.
  always_comb begin
    src_a     = rf_data_a;
    src_b     = rf_data_b;
    fwd_sel_a = 3'd0;
    fwd_sel_b = 3'd0;
    haz_a     = 1'b0;
    haz_b     = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (e_valid[k] && (e_rd[k] == rs_addr) && (rs_addr != '0)) begin
        fwd_sel_a = 3'(k);
        src_a     = ((k == LOAD_STAGE) && !e_ready[k]) ? mem_data : e_data[k];
        haz_a     = !e_ready[k] && (k < LOAD_STAGE);
      end
      if (e_valid[k] && (e_rd[k] == rt_addr) && (rt_addr != '0)) begin
        fwd_sel_b = 3'(k);
        src_b     = ((k == LOAD_STAGE) && !e_ready[k]) ? mem_data : e_data[k];
        haz_b     = !e_ready[k] && (k < LOAD_STAGE);
      end
    end
    stall = haz_a | haz_b;
  end

  // Count stall cycles, holding at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - self-checking bench for forward_scoreboard
module tb_forward_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int LS = 2;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_wen;
  logic [AW-1:0] ex_rd;
  logic          ex_is_load;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] mem_data;
  logic          flush;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rf_data_a;
  logic [DW-1:0] rf_data_b;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic [2:0]    fwd_sel_a;
  logic [2:0]    fwd_sel_b;
  logic          stall;
  logic [15:0]   stall_count;

  int checks = 0;
  int errors = 0;

  forward_scoreboard #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .LOAD_STAGE(LS)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_result(ex_result), .mem_data(mem_data), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .src_a(src_a), .src_b(src_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of in-flight writers, front = one cycle past execute.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    logic          pend;
  } rec_t;

  rec_t pipe[$];
  int   m_count;

  function automatic void model_clear();
    rec_t b;
    b = '0;
    pipe.delete();
    for (int i = 0; i < D; i++) pipe.push_back(b);
    m_count = 0;
  endfunction

  function automatic void model_fwd(input logic [AW-1:0] addr, input logic [DW-1:0] rf,
                                    input logic [DW-1:0] md, output logic [DW-1:0] val,
                                    output logic [2:0] sel, output logic hazard);
    logic found;
    val = rf; sel = 3'd0; hazard = 1'b0; found = 1'b0;
    for (int i = 0; i < pipe.size(); i++) begin
      if (!found && pipe[i].v && addr != 0 && pipe[i].rd == addr) begin
        found = 1'b1;
        sel   = 3'(i + 1);
        if (pipe[i].pend && (i + 1 == LS)) val = md;
        else val = pipe[i].d;
        hazard = pipe[i].pend && (i + 1 < LS);
      end
    end
  endfunction

  function automatic void model_step(input logic do_stall);
    rec_t r;
    r = pipe[LS-1];
    if (r.pend) begin
      r.d = mem_data;
      r.pend = 1'b0;
      pipe[LS-1] = r;
    end
    r.v    = ex_valid && ex_wen && !flush && !do_stall && ex_rd != 0;
    r.rd   = ex_rd;
    r.d    = ex_result;
    r.pend = r.v && ex_is_load;
    pipe.push_front(r);
    void'(pipe.pop_back());
    if (do_stall && m_count < 65535) m_count++;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] rd, input logic ld,
                       input logic [DW-1:0] res, input logic fl, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic [DW-1:0] md);
    @(negedge clk);
    ex_valid = v; ex_wen = w; ex_rd = rd; ex_is_load = ld; ex_result = res; flush = fl;
    rs_addr = rs; rt_addr = rt; mem_data = md;
    rf_data_a = 32'hA0A0_0000 + 32'(rs);
    rf_data_b = 32'hB0B0_0000 + 32'(rt);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_valid = 0; ex_wen = 0; ex_rd = 0; ex_is_load = 0; ex_result = 0; flush = 0;
    rs_addr = 0; rt_addr = 0; mem_data = 0; rf_data_a = 0; rf_data_b = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 1, 5'd3, 0, 32'h33, 0, 5'd0, 5'd0, 32'h0);
    drive(0, 0, 5'd0, 0, 32'h0, 0, 5'd3, 5'd3, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++; if (fwd_sel_a !== 3'd0) begin errors++; $display("FAIL reset_sel_a got %0d exp 0", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 3'd0) begin errors++; $display("FAIL reset_sel_b got %0d exp 0", fwd_sel_b); end
    checks++; if (src_a !== 32'hA0A0_0003) begin errors++; $display("FAIL reset_src_a got %h exp a0a00003", src_a); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    drive(1, 1, 5'd3, 0, 32'h11, 0, 5'd0, 5'd0, 32'h0);
    drive(0, 0, 5'd0, 0, 32'h0, 0, 5'd3, 5'd0, 32'h0);
    checks++; if (fwd_sel_a !== 3'd1) begin errors++; $display("FAIL b2b_sel got %0d exp 1", fwd_sel_a); end
    checks++; if (src_a !== 32'h11) begin errors++; $display("FAIL b2b_src got %h exp 11", src_a); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", stall); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 1, 5'd4, 0, 32'hA, 0, 5'd0, 5'd0, 32'h0);
    drive(1, 1, 5'd4, 0, 32'hB, 0, 5'd0, 5'd0, 32'h0);
    drive(0, 0, 5'd0, 0, 32'h0, 0, 5'd0, 5'd4, 32'h0);
    checks++; if (fwd_sel_b !== 3'd1) begin errors++; $display("FAIL prio_sel got %0d exp 1", fwd_sel_b); end
    checks++; if (src_b !== 32'hB) begin errors++; $display("FAIL prio_src got %h exp b", src_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 5'd5, 1, 32'h0, 0, 5'd0, 5'd0, 32'h0);
    drive(1, 1, 5'd7, 0, 32'h99, 0, 5'd5, 5'd0, 32'h1234);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    checks++; if (fwd_sel_a !== 3'd1) begin errors++; $display("FAIL lu_sel1 got %0d exp 1", fwd_sel_a); end
    drive(1, 1, 5'd7, 0, 32'h99, 0, 5'd5, 5'd0, 32'hDEAD);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unstall got %b exp 0", stall); end
    checks++; if (fwd_sel_a !== 3'd2) begin errors++; $display("FAIL lu_sel2 got %0d exp 2", fwd_sel_a); end
    checks++; if (src_a !== 32'hDEAD) begin errors++; $display("FAIL lu_src got %h exp dead", src_a); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", stall_count); end
    drive(0, 0, 5'd0, 0, 32'h0, 0, 5'd5, 5'd7, 32'h0BAD);
    checks++; if (fwd_sel_a !== 3'd3) begin errors++; $display("FAIL lu_sel3 got %0d exp 3", fwd_sel_a); end
    checks++; if (src_a !== 32'hDEAD) begin errors++; $display("FAIL lu_captured got %h exp dead", src_a); end
    checks++; if (src_b !== 32'h99) begin errors++; $display("FAIL lu_held_insert got %h exp 99", src_b); end
  endtask

  task automatic test_r0_and_flush();
    do_reset();
    drive(1, 1, 5'd0, 0, 32'h7, 0, 5'd0, 5'd0, 32'h0);
    drive(1, 1, 5'd6, 0, 32'h66, 1, 5'd0, 5'd0, 32'h0);
    checks++; if (fwd_sel_a !== 3'd0) begin errors++; $display("FAIL r0_sel got %0d exp 0", fwd_sel_a); end
    checks++; if (src_a !== 32'hA0A0_0000) begin errors++; $display("FAIL r0_src got %h exp a0a00000", src_a); end
    drive(0, 0, 5'd0, 0, 32'h0, 0, 5'd6, 5'd6, 32'h0);
    checks++; if (fwd_sel_a !== 3'd0) begin errors++; $display("FAIL flush_sel got %0d exp 0", fwd_sel_a); end
    checks++; if (src_b !== 32'hB0B0_0006) begin errors++; $display("FAIL flush_src got %h exp b0b00006", src_b); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 5'd5, 1, 32'h0, 0, 5'd0, 5'd0, 32'h0);
    drive(1, 1, 5'd8, 1, 32'h0, 0, 5'd5, 5'd0, 32'h0);
    drive(1, 1, 5'd8, 1, 32'h0, 0, 5'd5, 5'd0, 32'h55);
    drive(0, 0, 5'd0, 0, 32'h0, 0, 5'd8, 5'd0, 32'h0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ms_pre_stall got %b exp 1", stall); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL ms_pre_count got %0d exp 1", stall_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ms_stall got %b exp 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL ms_count got %0d exp 0", stall_count); end
    checks++; if (fwd_sel_a !== 3'd0) begin errors++; $display("FAIL ms_sel got %0d exp 0", fwd_sel_a); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 5'd0, 0, 32'h0, 0, 5'd8, 5'd5, 32'h0);
    checks++; if (fwd_sel_a !== 3'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL ms_after sel %0d stall %b exp 0 0", fwd_sel_a, stall);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ea, eb;
    logic [2:0]    sa, sb;
    logic          ha, hb, es;
    do_reset();
    model_clear();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 5) != 0, AW'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 9) == 0,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom);
      model_fwd(rs_addr, rf_data_a, mem_data, ea, sa, ha);
      model_fwd(rt_addr, rf_data_b, mem_data, eb, sb, hb);
      es = ha | hb;
      checks++; if (src_a !== ea) begin errors++; $display("FAIL rnd_src_a cyc %0d got %h exp %h", n, src_a, ea); end
      checks++; if (src_b !== eb) begin errors++; $display("FAIL rnd_src_b cyc %0d got %h exp %h", n, src_b, eb); end
      checks++; if (fwd_sel_a !== sa) begin errors++; $display("FAIL rnd_sel_a cyc %0d got %0d exp %0d", n, fwd_sel_a, sa); end
      checks++; if (fwd_sel_b !== sb) begin errors++; $display("FAIL rnd_sel_b cyc %0d got %0d exp %0d", n, fwd_sel_b, sb); end
      checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", n, stall, es); end
      checks++; if (stall_count !== 16'(m_count)) begin
        errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, stall_count, m_count);
      end
      model_step(es);
    end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_priority();
    test_load_use();
    test_r0_and_flush();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
